// File: rtl/bu_pkg.sv
// Shared branch-unit definitions: funct3 codes, 2-bit counter encoding and
// the condition evaluator also used by the single-cycle core.
package bu_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // flags = {v,c,n,z}; unsigned compares use c=1 as "no borrow" (a >= b)
  function automatic logic bu_cond(input logic [2:0] funct3, input logic [3:0] flags);
    logic v, c, n, z;
    {v, c, n, z} = flags;
    case (funct3)
      BEQ:     bu_cond = z;
      BNE:     bu_cond = ~z;
      BLT:     bu_cond = n ^ v;
      BGE:     bu_cond = ~(n ^ v);
      BLTU:    bu_cond = ~c;
      BGEU:    bu_cond = c;
      default: bu_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bu_predict_if.sv
// Fetch-prediction and execute-resolution bus between the pipeline and
// the branch predictor.
interface bu_predict_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
);
  logic [XLEN-1:0]   fetch_pc;
  logic              pred_taken;
  logic              ex_valid;
  logic              ex_branch;
  logic [XLEN-1:0]   ex_pc;
  logic [2:0]        ex_funct3;
  logic [3:0]        ex_flags;
  logic              ex_pred;
  logic              res_valid;
  logic              res_taken;
  logic              res_mispred;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] miss_count;

  modport master (
    output fetch_pc, ex_valid, ex_branch, ex_pc, ex_funct3, ex_flags, ex_pred,
    input  pred_taken, res_valid, res_taken, res_mispred, br_count, miss_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_branch, ex_pc, ex_funct3, ex_flags, ex_pred,
    output pred_taken, res_valid, res_taken, res_mispred, br_count, miss_count
  );
endinterface

// File: rtl/bu_predict_sat_ctr2.sv
// Next-state logic of a 2-bit saturating counter: inc moves towards ST,
// otherwise towards SNT, holding at either end.
module sat_ctr2
  import bu_pkg::*;
(
  input  ctr_t cur,
  input  logic inc,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/bu_predict.sv
// Branch unit with a PC-indexed table of 2-bit counters: combinational
// prediction for fetch, registered resolve/mispredict and statistics for execute.
module bu_predict
  import bu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int STAT_W = 16
) (
  input logic          clk,
  input logic          rst,
  bu_predict_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  ctr_t             bht [DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             resolve;
  logic             mispred;
  ctr_t             upd;
  logic             unused_pc_bits;

  assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
  assign ex_idx    = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                            bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

  assign cond    = bu_cond(bus.ex_funct3, bus.ex_flags);
  assign resolve = bus.ex_valid & bus.ex_branch;
  assign mispred = resolve & (cond ^ bus.ex_pred);

  // Read returns the pre-edge counter even when the same entry updates this cycle
  assign bus.pred_taken = bht[fetch_idx][1];

  sat_ctr2 u_sat_ctr2 (
    .cur (bht[ex_idx]),
    .inc (cond),
    .nxt (upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) bht[i] <= WNT;
      bus.res_valid   <= 1'b0;
      bus.res_taken   <= 1'b0;
      bus.res_mispred <= 1'b0;
      bus.br_count    <= '0;
      bus.miss_count  <= '0;
    end else begin
      if (resolve) bht[ex_idx] <= upd;
      bus.res_valid   <= resolve;
      bus.res_taken   <= resolve & cond;
      bus.res_mispred <= mispred;
      if (resolve && (bus.br_count != '1))   bus.br_count   <= bus.br_count + 1'b1;
      if (mispred && (bus.miss_count != '1)) bus.miss_count <= bus.miss_count + 1'b1;
    end
  end

endmodule
